// File: rtl/tia_multiphase_clock.sv
// -----------------------------------------------------------------------------
// tia_multiphase_clock
//   Generates PHASES non-overlapping phase clocks from the master clk. Each
//   phase is preceded by GAP_CYCLES all-inactive cycles and is then active for
//   HIGH_CYCLES cycles. Phases run in order 0..PHASES-1 and then wrap.
//
// Ports:
//   clk          master clock; all state changes happen on posedge
//   rsynl        asynchronous active-low reset
//   rsyn         synchronous resync, active high; has priority over hold
//   hold         freezes sequencing while high (frame_start forced low)
//   phi          phase clocks; bit k is active during phase k
//   phase_idx    index of the current or upcoming phase
//   frame_start  one-cycle pulse on the first active cycle of phi[0]
//   running      set when phi[0] is first produced after reset/resync
//
// Build option:
//   TIA_MULTIPHASE_TRISTATE_EN - inactive phi bits drive z and active bits
//   drive 1, as on the legacy biphase outputs. Otherwise phi is a plain
//   registered 0/1 vector. Timing is identical in both builds.
// -----------------------------------------------------------------------------
module tia_multiphase_clock #(
    parameter int PHASES      = 2,
    parameter int HIGH_CYCLES = 1,
    parameter int GAP_CYCLES  = 1,
    parameter int CNT_W       = 4,
    parameter int IDX_W       = 1
) (
    input  logic              clk,
    input  logic              rsynl,
    input  logic              rsyn,
    input  logic              hold,
    output logic [PHASES-1:0] phi,
    output logic [IDX_W-1:0]  phase_idx,
    output logic              frame_start,
    output logic              running
);

    localparam int MAX_CYC = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;

    // Parameter legality, caught at elaboration.
    generate
        if (PHASES < 2) begin : g_bad_phases
            $error("tia_multiphase_clock: PHASES must be >= 2");
        end
        if (HIGH_CYCLES < 1) begin : g_bad_high
            $error("tia_multiphase_clock: HIGH_CYCLES must be >= 1");
        end
        if (GAP_CYCLES < 1) begin : g_bad_gap
            $error("tia_multiphase_clock: GAP_CYCLES must be >= 1");
        end
        if (CNT_W < 1 || CNT_W > 30 || (MAX_CYC - 1) >= (1 << CNT_W)) begin : g_bad_cnt_w
            $error("tia_multiphase_clock: CNT_W too narrow for max(HIGH_CYCLES,GAP_CYCLES)-1");
        end
        if (IDX_W < 1 || IDX_W > 30 || (PHASES - 1) >= (1 << IDX_W)) begin : g_bad_idx_w
            $error("tia_multiphase_clock: IDX_W too narrow for PHASES-1");
        end
    endgenerate

    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(PHASES - 1);

    typedef enum logic {
        S_GAP  = 1'b0,
        S_HIGH = 1'b1
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [IDX_W-1:0]   idx;
    logic [PHASES-1:0]  phi_q;   // per-bit active flag (tristate enable in that build)

    always_ff @(posedge clk or negedge rsynl) begin
        if (!rsynl) begin
            state       <= S_GAP;
            count       <= '0;
            idx         <= '0;
            phi_q       <= '0;
            frame_start <= 1'b0;
            running     <= 1'b0;
        end else if (rsyn) begin
            state       <= S_GAP;
            count       <= '0;
            idx         <= '0;
            phi_q       <= '0;
            frame_start <= 1'b0;
            running     <= 1'b0;
        end else if (hold) begin
            // Everything freezes, including an active phase; only the
            // frame strobe is dropped so it never stretches.
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            case (state)
                S_GAP: begin
                    if (count == GAP_LAST) begin
                        state <= S_HIGH;
                        count <= '0;
                        phi_q <= PHASES'(1) << idx;
                        if (idx == '0) begin
                            frame_start <= 1'b1;
                            running     <= 1'b1;
                        end
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                S_HIGH: begin
                    if (count == HIGH_LAST) begin
                        state <= S_GAP;
                        count <= '0;
                        phi_q <= '0;
                        idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    state <= S_GAP;
                    count <= '0;
                    phi_q <= '0;
                end
            endcase
        end
    end

    assign phase_idx = idx;

`ifdef TIA_MULTIPHASE_TRISTATE_EN
    generate
        for (genvar k = 0; k < PHASES; k++) begin : g_phi_tri
            assign phi[k] = phi_q[k] ? 1'b1 : 1'bz;
        end
    endgenerate
`else
    assign phi = phi_q;
`endif

endmodule

// File: tb/tb_tia_multiphase_clock.sv
module tb_tia_multiphase_clock;

    logic       clk = 1'b0;
    logic       rsynl = 1'b0;
    logic       rsyn = 1'b0;
    logic       hold = 1'b0;

    logic [1:0] phi0;
    logic [0:0] idx0;
    logic       fs0, run0;
    logic [2:0] phi1;
    logic [1:0] idx1;
    logic       fs1, run1;

    int n_chk = 0;
    int n_err = 0;

    // Model state: number of advancing edges since the last reset/resync,
    // and whether the most recent edge advanced the sequence.
    int t   = 0;
    bit adv = 0;

    always #5 clk = ~clk;

    tia_multiphase_clock dut0 (
        .clk(clk), .rsynl(rsynl), .rsyn(rsyn), .hold(hold),
        .phi(phi0), .phase_idx(idx0), .frame_start(fs0), .running(run0)
    );

    tia_multiphase_clock #(
        .PHASES(3), .HIGH_CYCLES(2), .GAP_CYCLES(3), .CNT_W(4), .IDX_W(2)
    ) dut1 (
        .clk(clk), .rsynl(rsynl), .rsyn(rsyn), .hold(hold),
        .phi(phi1), .phase_idx(idx1), .frame_start(fs1), .running(run1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", tag, obs, exp, t, $time);
        end
    endtask

    // Expected outputs from the frame position: the period is split into
    // PHASES slots of (GAP+HIGH) cycles; the first GAP cycles of a slot are idle.
    task automatic model(input int np, input int hc, input int gc, input int tt, input bit a,
                         output logic [31:0] e_phi, output logic [31:0] e_idx,
                         output logic [31:0] e_fs, output logic [31:0] e_run);
        int q, k, r;
        q = tt % (np * (hc + gc));
        k = q / (hc + gc);
        r = q % (hc + gc);
        e_phi = '0;
        for (int b = 0; b < np; b++) begin
`ifdef TIA_MULTIPHASE_TRISTATE_EN
            e_phi[b] = (r >= gc && b == k) ? 1'b1 : 1'bz;
`else
            e_phi[b] = (r >= gc && b == k) ? 1'b1 : 1'b0;
`endif
        end
        e_idx = 32'(k);
        e_fs  = {31'b0, (a && k == 0 && r == gc)};
        e_run = {31'b0, (tt >= gc)};
    endtask

    task automatic check_all();
        logic [31:0] ep, ei, ef, er;
        model(2, 1, 1, t, adv, ep, ei, ef, er);
        chk("d0.phi", 32'(phi0), ep);
        chk("d0.idx", 32'(idx0), ei);
        chk("d0.frame_start", 32'(fs0), ef);
        chk("d0.running", 32'(run0), er);
        model(3, 2, 3, t, adv, ep, ei, ef, er);
        chk("d1.phi", 32'(phi1), ep);
        chk("d1.idx", 32'(idx1), ei);
        chk("d1.frame_start", 32'(fs1), ef);
        chk("d1.running", 32'(run1), er);
        chk("d1.nonoverlap", 32'($countones(phi1) <= 1), 32'd1);
    endtask

    // One clock: update the model with the inputs seen on the edge, then check.
    task automatic step();
        @(posedge clk);
        if (rsyn) begin
            t = 0; adv = 0;
        end else if (hold) begin
            adv = 0;
        end else begin
            t++; adv = 1;
        end
        #1 check_all();
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1 check_all();
        @(negedge clk) rsynl = 1'b1;

        // Free-running from reset
        repeat (12) step();

        // Hold while phi[1] of the default instance is active
        for (int i = 0; i < 8 && (t % 4) != 3; i++) step();
        chk("hold.setup_phi1", 32'(phi0), 32'h2);
        hold = 1'b1;
        repeat (5) step();
        hold = 1'b0;
        step();
        chk("hold.release_gap", 32'(phi0), 32'h0);
        step();
        chk("hold.release_phi0", 32'(phi0), 32'h1);
        chk("hold.release_fs", 32'(fs0), 32'h1);

        // Resync together with hold, mid-frame
        repeat (3) step();
        rsyn = 1'b1; hold = 1'b1;
        repeat (3) step();
        rsyn = 1'b0; hold = 1'b0;
        step();
        chk("rsyn.first_phi0", 32'(phi0), 32'h1);
        repeat (20) step();

        // Randomised hold/resync
        for (int i = 0; i < 600; i++) begin
            hold = ($urandom_range(0, 3) == 0);
            rsyn = ($urandom_range(0, 24) == 0);
            step();
        end
        hold = 1'b0; rsyn = 1'b0;

        // Asynchronous reset between edges while phi[0] is active
        for (int i = 0; i < 8 && (t % 4) != 1; i++) step();
        chk("areset.setup_phi0", 32'(phi0), 32'h1);
        #3 rsynl = 1'b0;
        #1;
        t = 0; adv = 0;
        check_all();
        #1 rsynl = 1'b1;
        repeat (40) step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tia_multiphase_clock.md
Name: tia_multiphase_clock

Overview:
- Parametrised successor to the TIA biphase clock generator.
- Derives PHASES non-overlapping phase clocks from the master clk. Each phase is high for HIGH_CYCLES and is separated from the next by GAP_CYCLES of all-inactive.
- Adds soft resync, hold/freeze, a phase-index output and a frame-start strobe.
- Feeds TIA sub-blocks (horizontal counter, object counters) that need more than two clock phases.

Parameters:
- PHASES, 2: number of phase outputs. Legal range is 2 or more.
- HIGH_CYCLES, 1: clk cycles each phase is active. Legal range is 1 or more.
- GAP_CYCLES, 1: all-inactive clk cycles before each phase. Legal range is 1 or more, which guarantees non-overlap.
- CNT_W, 4: width of the internal cycle counter. Must hold max(HIGH_CYCLES, GAP_CYCLES)-1.
- IDX_W, 1: width of phase_idx. Must hold PHASES-1.

Ports:
- clk  in  1  master clock. All state changes on posedge.
- rsynl  in  1  asynchronous active-low reset.
- rsyn  in  1  synchronous resync, active high. Has priority over hold.
- hold  in  1  freezes sequencing while high.
- phi  out  PHASES  phase clocks. Bit k is active during phase k.
- phase_idx  out  IDX_W  index of the current or upcoming phase.
- frame_start  out  1  single-cycle pulse on the first active cycle of phi[0].
- running  out  1  high once the first phi[0] has been produced since reset or resync.

Behaviour:
- FSM states: GAP and HIGH. Registers are state, count (CNT_W) and idx (IDX_W). All outputs are registered, with no combinational path from inputs to outputs.
- Reset (rsynl=0), applied asynchronously: state=GAP, count=0, idx=0, phi all inactive, frame_start=0, running=0.
- GAP state:
  - phi is all inactive.
  - When count reaches GAP_CYCLES-1: go to HIGH, count=0, and phi[idx] goes active on the same edge.
  - Otherwise count increments.
- HIGH state:
  - Only phi[idx] is active.
  - When count reaches HIGH_CYCLES-1: go to GAP, count=0, phi goes inactive, and idx becomes idx+1.
  - idx wraps from PHASES-1 to 0.
  - Otherwise count increments.
- Resulting sequence for the defaults: GAP, phi0, GAP, phi1, GAP, phi0, and so on.
  - Period is PHASES*(HIGH_CYCLES+GAP_CYCLES) clk cycles; 4 for the defaults.
  - After reset release, the first phi[0] appears on the GAP_CYCLES-th posedge.
- frame_start is 1 exactly in the cycle where phi[0] first becomes active, for one cycle per frame.
- running:
  - Set on the edge where phi[0] first goes active.
  - Stays 1 until reset or rsyn.
- rsyn=1 on a posedge:
  - Synchronously loads the reset values, including running=0.
  - While held high, outputs stay in the reset state.
  - Sequencing restarts from GAP, idx=0 on the first posedge after rsyn falls, which is count 0 of the gap.
- hold=1 on a posedge (with rsyn=0):
  - state, count, idx, phi and running are unchanged, so a phase that is already active stays active.
  - frame_start is forced to 0.
  - Sequencing resumes exactly where it stopped once hold falls.
- Simultaneous rsyn and hold: rsyn wins.
- Simultaneous count terminal and idx wrap: both take effect on the same edge.
- rsynl asserted mid-phase: phi goes inactive immediately, without waiting for clk.
- Non-overlap invariant: at most one phi bit is active in any cycle, and two consecutive active phases are always separated by at least GAP_CYCLES inactive cycles.
- Illegal parameters (PHASES<2, HIGH_CYCLES<1, GAP_CYCLES<1, CNT_W or IDX_W too narrow) raise an elaboration-time error.

Optional Feature:
- Macro: TIA_MULTIPHASE_TRISTATE_EN.
- Defined: inactive phi bits drive high-impedance (z) and active bits drive 1, matching the legacy biphase outputs.
  - Implemented as a registered enable per bit gating a continuous tristate assign.
- Undefined: phi is a plain registered vector, inactive = 0, active = 1.
- Sequencing, timing and all other outputs are identical in both builds.

Test Plan:
- Defaults, reset released, 12 clocks with no hold or rsyn -> phi pattern by cycle is 00, 01, 00, 10, 00, 01, and so on. frame_start is high on cycles 1, 5 and 9. running rises at cycle 1. phase_idx follows 0, 0, 1, 1, 0, 0.
- PHASES=3, HIGH_CYCLES=2, GAP_CYCLES=3 -> period 15. Each phi bit is high for exactly 2 cycles. Each phase is preceded by 3 all-zero cycles. phi[0] first rises on the 3rd posedge after reset release. No two bits are ever active together (checked every cycle).
- Defaults: hold=1 for 5 cycles while phi[1] is active -> phi stays at 10 for 5 extra cycles and frame_start stays 0. After release, the next edge gives 00, then 01 with a frame_start pulse.
- Defaults: rsyn=1 for 3 cycles mid-frame, asserted together with hold=1 -> phi 00, idx 0, running 0 while asserted. After rsyn falls, phi[0] first rises on the 1st posedge (GAP_CYCLES=1).
- Async reset: rsynl pulled low between clk edges while phi[0] is active -> phi becomes 00 before the next posedge. Repeated with TIA_MULTIPHASE_TRISTATE_EN defined -> inactive bits read z (checked with ===), active bits read 1.
